lc3_operand_regfile: RTL and testbench
======================================

Name: lc3_operand_regfile

Overview:
- Operand-supply and writeback end of the LC-3 datapath ALU.
- Holds R0–R7 and decodes IR register/immediate fields. Drives the ALU A and B operands.
- Captures the result returned over the datapath bus into the destination register and the NZP condition codes.
- Latches BEN for the control FSM's branch decision.

Parameters:
- DATA_W, 16, register/bus width (fixed at 16 for LC-3; parameterised for bench reuse)
- NUM_REGS, 8, general-purpose register count (index width = $clog2(NUM_REGS))

Ports:
- Clk  input  1  system clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- IR  input  16  current instruction register contents
- Bus_In  input  16  datapath bus (ALU result, memory data, PC, etc.)
- LD_REG  input  1  write Bus_In into selected DR this edge
- LD_CC  input  1  update NZP from Bus_In this edge
- LD_BEN  input  1  latch branch-enable this edge
- DRMUX  input  1  0: DR = IR[11:9]; 1: DR = R7
- SR1MUX  input  1  0: SR1 = IR[8:6]; 1: SR1 = IR[11:9]
- SR1_Out  output  16  contents of SR1 (ALU operand A, also address adder)
- ALU_B  output  16  IR[5]=0: R[IR[2:0]]; IR[5]=1: sign-extended IR[4:0]
- NZP  output  3  condition codes {N,Z,P}
- BEN  output  1  registered branch enable

Behaviour:
Reset:
- Reset high at a rising edge clears R0–R7 to 16'h0000, sets NZP = 3'b010 and BEN = 0.
- Reset overrides LD_REG/LD_CC/LD_BEN asserted in the same cycle.
- Reset mid-operation discards any pending write.

Reads:
- Combinational, zero latency: SR1_Out and ALU_B reflect current register state and IR in the same cycle.
- SR1 index is a 3-bit mux selected by SR1MUX.
- SR2 index is always IR[2:0].
- Immediate: ALU_B = {{11{IR[4]}}, IR[4:0]} when IR[5]=1 (e.g. IR[4:0]=5'b10000 -> 16'hFFF0).

Register write:
- On a rising edge with LD_REG=1, R[DR] <= Bus_In. No other register changes.
- DR = 3'd7 when DRMUX=1, otherwise IR[11:9].

Condition codes:
- On a rising edge with LD_CC=1, NZP <= 3'b100 if Bus_In[15]; 3'b010 if Bus_In==0; else 3'b001.
- Exactly one bit is set at all times after reset.

Branch enable:
- On a rising edge with LD_BEN=1, BEN <= (IR[11]&NZP[2]) | (IR[10]&NZP[1]) | (IR[9]&NZP[0]).
- Uses the NZP value before any same-edge LD_CC update (registered old value).

Simultaneous events:
- LD_REG, LD_CC and LD_BEN may all assert in one cycle; each acts independently.
- Same-cycle read and write of the same register: SR1_Out/ALU_B show the old value until the edge, unless the optional feature below is compiled in.

Held state:
- With no load strobe, all state holds indefinitely.

Optional Feature:
- Macro: LC3_REGFILE_BYPASS_EN.
- Defined: when LD_REG=1 and DR equals the SR1 or SR2 index, the matching read output returns Bus_In combinationally in that cycle. For ALU_B this applies only when IR[5]=0.
- Undefined: reads always return stored register contents (old value during a write cycle).
- Reset behaviour is identical in both builds.

Decomposition:
- Shared package lc3_pkg:
  - typedef reg_idx_t (logic [2:0])
  - typedef nzp_t (logic [2:0])
  - constants NZP_N=3'b100, NZP_Z=3'b010, NZP_P=3'b001, REG_R7=3'd7
  - function sext5 (and sext6/9/11 for the other datapath blocks)
- One sub-module: lc3_nzp_unit (NZP register + BEN latch, Clk/Reset/LD_CC/LD_BEN/Bus_In/IR[11:9]).
- The register array stays in the top module.

Test Plan:
- Reset with LD_REG=1, Bus_In=16'h1234 -> all regs 0, NZP=3'b010, BEN=0, no write.
- Write and read back:
  - Stimulus: IR[11:9]=3, LD_REG=1, Bus_In=16'hBEEF, DRMUX=0; next cycle IR[8:6]=3, SR1MUX=0.
  - Response: SR1_Out=16'hBEEF; R0–R2 and R4–R7 remain 0.
- DRMUX=1, Bus_In=16'h3001, LD_REG=1 -> R7=16'h3001. Then IR[5]=0, IR[2:0]=7 -> ALU_B=16'h3001.
- Immediate and condition codes:
  - Stimulus: IR[5]=1, IR[4:0]=5'b11111.
  - Response: ALU_B=16'hFFFF.
  - Then LD_CC with Bus_In=16'h8000 -> NZP=100; 16'h0000 -> 010; 16'h0001 -> 001.
- BEN uses pre-edge NZP:
  - Stimulus: NZP=010, IR[11:9]=3'b010, LD_BEN=1 and LD_CC=1 with Bus_In=16'h0005 on the same edge.
  - Response: BEN=1, NZP=001.
- Same-cycle read/write:
  - Stimulus: R2 holds 16'h0001; LD_REG=1, DR=2, Bus_In=16'h00AA, SR1=2.
  - Response: SR1_Out=16'h0001 before the edge (16'h00AA with LC3_REGFILE_BYPASS_EN); 16'h00AA after the edge in both builds.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath types, condition-code constants and sign-extension helpers.
package lc3_pkg;

  typedef logic [2:0] reg_idx_t;
  typedef logic [2:0] nzp_t;

  localparam nzp_t     NZP_N  = 3'b100;
  localparam nzp_t     NZP_Z  = 3'b010;
  localparam nzp_t     NZP_P  = 3'b001;
  localparam reg_idx_t REG_R7 = 3'd7;

  function automatic logic [15:0] sext5(input logic [4:0] imm);
    return {{11{imm[4]}}, imm};
  endfunction

  function automatic logic [15:0] sext6(input logic [5:0] imm);
    return {{10{imm[5]}}, imm};
  endfunction

  function automatic logic [15:0] sext9(input logic [8:0] imm);
    return {{7{imm[8]}}, imm};
  endfunction

  function automatic logic [15:0] sext11(input logic [10:0] imm);
    return {{5{imm[10]}}, imm};
  endfunction

endpackage

// File: rtl/lc3_nzp_unit.sv
// NZP condition-code register and branch-enable latch.
module lc3_nzp_unit
  import lc3_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LD_CC,
  input  logic              LD_BEN,
  input  logic [DATA_W-1:0] Bus_In,
  input  logic [2:0]        IR_nzp,
  output nzp_t              NZP,
  output logic              BEN
);

  nzp_t nzp_q, nzp_d, nzp_new;
  logic ben_q, ben_d;

  always_comb begin
    nzp_new = NZP_P;
    if (Bus_In[DATA_W-1]) begin
      nzp_new = NZP_N;
    end else if (Bus_In == '0) begin
      nzp_new = NZP_Z;
    end
  end

  // BEN is evaluated against nzp_q, so a same-edge LD_CC never affects it.
  always_comb begin
    nzp_d = nzp_q;
    ben_d = ben_q;
    if (LD_CC) begin
      nzp_d = nzp_new;
    end
    if (LD_BEN) begin
      ben_d = |(IR_nzp & nzp_q);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      nzp_q <= NZP_Z;
      ben_q <= 1'b0;
    end else begin
      nzp_q <= nzp_d;
      ben_q <= ben_d;
    end
  end

  assign NZP = nzp_q;
  assign BEN = ben_q;

endmodule

// File: rtl/lc3_operand_regfile.sv
// LC-3 register file R0-R7 with ALU operand muxing, writeback, NZP and BEN.
// Optional write-to-read bypass is enabled by defining LC3_REGFILE_BYPASS_EN.
module lc3_operand_regfile
  import lc3_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       IR,
  input  logic [DATA_W-1:0] Bus_In,
  input  logic              LD_REG,
  input  logic              LD_CC,
  input  logic              LD_BEN,
  input  logic              DRMUX,
  input  logic              SR1MUX,
  output logic [DATA_W-1:0] SR1_Out,
  output logic [DATA_W-1:0] ALU_B,
  output logic [2:0]        NZP,
  output logic              BEN
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  reg_idx_t          dr, sr1, sr2;
  logic [DATA_W-1:0] sr1_val, sr2_val, imm_ext;
  logic              unused_ir;

  assign unused_ir = ^IR[15:12];

  assign dr      = DRMUX  ? REG_R7   : IR[11:9];
  assign sr1     = SR1MUX ? IR[11:9] : IR[8:6];
  assign sr2     = IR[2:0];
  assign imm_ext = {{(DATA_W-5){IR[4]}}, IR[4:0]};

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (LD_REG) begin
      regs_d[IdxW'(dr)] = Bus_In;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    sr1_val = regs_q[IdxW'(sr1)];
    sr2_val = regs_q[IdxW'(sr2)];
`ifdef LC3_REGFILE_BYPASS_EN
    // Forward the in-flight writeback so dependent ops see it this cycle.
    if (LD_REG && (dr == sr1)) begin
      sr1_val = Bus_In;
    end
    if (LD_REG && (dr == sr2)) begin
      sr2_val = Bus_In;
    end
`endif
  end

  assign SR1_Out = sr1_val;
  assign ALU_B   = IR[5] ? imm_ext : sr2_val;

  lc3_nzp_unit #(
    .DATA_W (DATA_W)
  ) u_nzp_unit (
    .Clk    (Clk),
    .Reset  (Reset),
    .LD_CC  (LD_CC),
    .LD_BEN (LD_BEN),
    .Bus_In (Bus_In),
    .IR_nzp (IR[11:9]),
    .NZP    (NZP),
    .BEN    (BEN)
  );

endmodule

// File: tb/tb_lc3_operand_regfile.sv
// Self-checking bench for lc3_operand_regfile: directed cases plus randomized traffic
// against an array-based reference model.
module tb_lc3_operand_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir = '0;
  logic [15:0] bus = '0;
  logic        ld_reg = 1'b0, ld_cc = 1'b0, ld_ben = 1'b0, drmux = 1'b0, sr1mux = 1'b0;
  logic [15:0] sr1_out, alu_b;
  logic [2:0]  nzp;
  logic        ben;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [15:0] m_regs [8];
  logic [2:0]  m_nzp;
  logic        m_ben;

  always #5 clk = ~clk;

  lc3_operand_regfile dut (
    .Clk     (clk),
    .Reset   (rst),
    .IR      (ir),
    .Bus_In  (bus),
    .LD_REG  (ld_reg),
    .LD_CC   (ld_cc),
    .LD_BEN  (ld_ben),
    .DRMUX   (drmux),
    .SR1MUX  (sr1mux),
    .SR1_Out (sr1_out),
    .ALU_B   (alu_b),
    .NZP     (nzp),
    .BEN     (ben)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input int idx);
    logic [15:0] v;
    int          dst;
    v   = m_regs[idx];
    dst = drmux ? 7 : int'(ir[11:9]);
`ifdef LC3_REGFILE_BYPASS_EN
    if (ld_reg && dst == idx) v = bus;
`else
    if (ld_reg && dst == idx && 1'b0) v = bus;
`endif
    return v;
  endfunction

  function automatic logic [15:0] model_alu_b();
    int imm;
    if (ir[5]) begin
      imm = $signed(ir[4:0]);
      return 16'(imm);
    end
    return model_read(int'(ir[2:0]));
  endfunction

  task automatic model_edge();
    int dst;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_nzp = 3'b010;
      m_ben = 1'b0;
    end else begin
      if (ld_ben) m_ben = (ir[11] && m_nzp == 3'b100) || (ir[10] && m_nzp == 3'b010) ||
                          (ir[9] && m_nzp == 3'b001);
      if (ld_cc) m_nzp = ($signed(bus) < 0) ? 3'b100 : (bus == 0) ? 3'b010 : 3'b001;
      dst = drmux ? 7 : int'(ir[11:9]);
      if (ld_reg) m_regs[dst] = bus;
    end
  endtask

  task automatic cycle(input logic [15:0] i_ir, input logic [15:0] i_bus, input logic i_ld_reg,
                       input logic i_ld_cc, input logic i_ld_ben, input logic i_drmux,
                       input logic i_sr1mux, input logic i_rst);
    int s1;
    @(negedge clk);
    ir = i_ir; bus = i_bus; ld_reg = i_ld_reg; ld_cc = i_ld_cc; ld_ben = i_ld_ben;
    drmux = i_drmux; sr1mux = i_sr1mux; rst = i_rst;
    #1;
    s1 = sr1mux ? int'(ir[11:9]) : int'(ir[8:6]);
    check("sr1_out", sr1_out, model_read(s1));
    check("alu_b", alu_b, model_alu_b());
    @(posedge clk);
    model_edge();
    #1;
    check("nzp", {13'd0, nzp}, {13'd0, m_nzp});
    check("ben", {15'd0, ben}, {15'd0, m_ben});
  endtask

  task automatic read_all();
    for (int i = 0; i < 8; i++) begin
      cycle(16'(i << 6), 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    foreach (m_regs[i]) m_regs[i] = '0;
    m_nzp = 3'b010;
    m_ben = 1'b0;
    @(posedge clk);
    #1;

    // Reset overrides all strobes
    cycle(16'h0E00, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_nzp", {13'd0, nzp}, 16'h0002);
    check("rst_ben", {15'd0, ben}, 16'h0000);
    read_all();

    // Write R3, read back via SR1 = IR[8:6]
    cycle(16'h0600, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(16'h00C0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("r3_beef", sr1_out, 16'hBEEF);
    read_all();

    // DRMUX selects R7
    cycle(16'h0000, 16'h3001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(16'h0007, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("r7_alu_b", alu_b, 16'h3001);

    // Immediates
    cycle(16'h003F, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("imm_ffff", alu_b, 16'hFFFF);
    cycle(16'h0030, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("imm_fff0", alu_b, 16'hFFF0);

    // Condition codes
    cycle(16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("cc_neg", {13'd0, nzp}, 16'h0004);
    cycle(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("cc_zero", {13'd0, nzp}, 16'h0002);
    cycle(16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("cc_pos", {13'd0, nzp}, 16'h0001);

    // BEN sees pre-edge NZP
    cycle(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(16'h0400, 16'h0005, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ben_old_nzp", {15'd0, ben}, 16'h0001);
    check("ben_nzp_new", {13'd0, nzp}, 16'h0001);

    // Same-cycle read/write of R2
    cycle(16'h0400, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    ir = 16'h0480; bus = 16'h00AA; ld_reg = 1'b1; ld_cc = 1'b0; ld_ben = 1'b0;
    drmux = 1'b0; sr1mux = 1'b0; rst = 1'b0;
    #1;
`ifdef LC3_REGFILE_BYPASS_EN
    check("rw_before", sr1_out, 16'h00AA);
`else
    check("rw_before", sr1_out, 16'h0001);
`endif
    @(posedge clk);
    model_edge();
    #1;
    check("rw_after", sr1_out, 16'h00AA);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cycle(16'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom), 1'($urandom_range(0, 63) == 0));
    end
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
